// File: rtl/keccak_pkg.sv
// Shared constants and types for the Keccak sponge absorb path.
package keccak_pkg;

    localparam int STATE_W        = 1600;

    localparam int RATE_SHA3_224  = 144;
    localparam int RATE_SHA3_256  = 136;
    localparam int RATE_SHA3_384  = 104;
    localparam int RATE_SHA3_512  = 72;
    localparam int RATE_SHAKE128  = 168;
    localparam int RATE_SHAKE256  = 136;

    localparam logic [7:0] DOMAIN_SHA3  = 8'h06;
    localparam logic [7:0] DOMAIN_SHAKE = 8'h1F;
    localparam logic [7:0] PAD_LAST     = 8'h80;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CAPTURE = 3'd1,
        ST_PAD     = 3'd2,
        ST_PRESENT = 3'd3,
        ST_ABORT   = 3'd4
    } absorb_state_t;

endpackage

// File: rtl/keccak_rate_buffer.sv
// Rate-sized byte buffer: byte-indexed write plus two byte-indexed XOR ports used for padding.
module keccak_rate_buffer
    import keccak_pkg::*;
#(
    parameter int RATE_BYTES = 72,
    parameter int IDX_W      = 7
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_clear,
    input  logic                    i_wr_en,
    input  logic [IDX_W-1:0]        i_wr_idx,
    input  logic [7:0]              i_wr_data,
    input  logic                    i_xa_en,
    input  logic [IDX_W-1:0]        i_xa_idx,
    input  logic [7:0]              i_xa_data,
    input  logic                    i_xb_en,
    input  logic [IDX_W-1:0]        i_xb_idx,
    input  logic [7:0]              i_xb_data,
    output logic [8*RATE_BYTES-1:0] o_buf
);

    logic [8*RATE_BYTES-1:0] r_buf;
    logic [8*RATE_BYTES-1:0] w_next;

    // Both XOR ports may hit the same byte, so their contributions are combined.
    always_comb begin
        w_next = r_buf;
        for (int i = 0; i < RATE_BYTES; i++) begin
            w_next[8*i +: 8] =
                ((i_wr_en && (i_wr_idx == IDX_W'(i))) ? i_wr_data : r_buf[8*i +: 8]) ^
                ((i_xa_en && (i_xa_idx == IDX_W'(i))) ? i_xa_data : 8'h00) ^
                ((i_xb_en && (i_xb_idx == IDX_W'(i))) ? i_xb_data : 8'h00);
        end
    end

    // Buffer storage with synchronous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_buf <= '0;
        end else if (i_clear) begin
            r_buf <= '0;
        end else begin
            r_buf <= w_next;
        end
    end

    assign o_buf = r_buf;

endmodule

// File: rtl/keccak_absorb_pad.sv
// Absorbs message bytes from a byte FIFO into rate blocks, applies multi-rate padding,
// and presents each block pre-XORed into the sponge state to the permutation.
module keccak_absorb_pad
    import keccak_pkg::*;
#(
    parameter int         RATE_BYTES = 72,
    parameter logic [7:0] DOMAIN     = DOMAIN_SHA3,
    parameter int         CNT_W      = $clog2(RATE_BYTES + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               go,
    input  logic               kill,
    input  logic               data_done,
    input  logic [7:0]         fifo_dout,
    input  logic               fifo_empty,
    output logic               fifo_rd,
    input  logic [STATE_W-1:0] state_in,
    output logic [STATE_W-1:0] state_out,
    output logic               blk_valid,
    input  logic               blk_ready,
    output logic               blk_last,
    output logic [CNT_W-1:0]   byte_count,
    output logic               busy,
    output logic               done
);

    localparam logic [CNT_W:0]   RATE_EXT = (CNT_W+1)'(RATE_BYTES);
    localparam logic [CNT_W-1:0] RATE_CNT = CNT_W'(RATE_BYTES);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(RATE_BYTES - 1);

    absorb_state_t           r_state;
    logic [CNT_W-1:0]        r_idx;
    logic                    r_rd_pending;
    logic                    r_blk_valid;
    logic                    r_blk_last;
    logic [CNT_W-1:0]        r_byte_count;
    logic                    r_busy;
    logic                    r_done;

    logic                    w_room;
    logic                    w_fifo_rd;
    logic                    w_kill;
    logic                    w_clear;
    logic                    w_wr_en;
    logic                    w_pad_en;
    logic [8*RATE_BYTES-1:0] w_buf;
    logic [STATE_W-1:0]      w_block;

    // A byte already in flight counts against the remaining room in the block.
    assign w_room    = ({1'b0, r_idx} + {{CNT_W{1'b0}}, r_rd_pending}) < RATE_EXT;
    assign w_fifo_rd = (r_state == ST_CAPTURE) && !fifo_empty && !kill && w_room;
    assign w_kill    = kill && (r_state != ST_IDLE);
    assign w_clear   = ((r_state == ST_IDLE) && go) || (r_state == ST_ABORT) || w_kill ||
                       ((r_state == ST_PRESENT) && blk_ready && !r_blk_last);
    assign w_wr_en   = (r_state == ST_CAPTURE) && r_rd_pending && !kill;
    assign w_pad_en  = (r_state == ST_PAD) && !kill;

    keccak_rate_buffer #(
        .RATE_BYTES (RATE_BYTES),
        .IDX_W      (CNT_W)
    ) u_buf (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (w_clear),
        .i_wr_en   (w_wr_en),
        .i_wr_idx  (r_idx),
        .i_wr_data (fifo_dout),
        .i_xa_en   (w_pad_en),
        .i_xa_idx  (r_idx),
        .i_xa_data (DOMAIN),
        .i_xb_en   (w_pad_en),
        .i_xb_idx  (LAST_IDX),
        .i_xb_data (PAD_LAST),
        .o_buf     (w_buf)
    );

    assign w_block    = STATE_W'(w_buf);
    assign state_out  = r_blk_valid ? (state_in ^ w_block) : state_in;
    assign fifo_rd    = w_fifo_rd;
    assign blk_valid  = r_blk_valid;
    assign blk_last   = r_blk_last;
    assign byte_count = r_byte_count;
    assign busy       = r_busy;
    assign done       = r_done;

    // Absorb FSM; kill overrides every other event outside IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_idx        <= '0;
            r_rd_pending <= 1'b0;
            r_blk_valid  <= 1'b0;
            r_blk_last   <= 1'b0;
            r_byte_count <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else if (w_kill) begin
            r_state      <= ST_ABORT;
            r_idx        <= '0;
            r_rd_pending <= 1'b0;
            r_blk_valid  <= 1'b0;
            r_blk_last   <= 1'b0;
            r_byte_count <= '0;
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (go) begin
                        r_state      <= ST_CAPTURE;
                        r_idx        <= '0;
                        r_rd_pending <= 1'b0;
                        r_busy       <= 1'b1;
                    end else begin
                        r_busy       <= 1'b0;
                    end
                end
                ST_CAPTURE: begin
                    r_rd_pending <= w_fifo_rd;
                    if (r_rd_pending) begin
                        r_idx <= r_idx + CNT_W'(1);
                    end
                    // A full block wins over end-of-message so exact multiples get a pad-only block.
                    if ((r_idx == RATE_CNT) && !r_rd_pending) begin
                        r_state      <= ST_PRESENT;
                        r_blk_valid  <= 1'b1;
                        r_blk_last   <= 1'b0;
                        r_byte_count <= r_idx;
                    end else if (data_done && fifo_empty && !r_rd_pending) begin
                        r_state      <= ST_PAD;
                    end
                end
                ST_PAD: begin
                    r_state      <= ST_PRESENT;
                    r_blk_valid  <= 1'b1;
                    r_blk_last   <= 1'b1;
                    r_byte_count <= r_idx;
                end
                ST_PRESENT: begin
                    if (blk_ready) begin
                        r_blk_valid <= 1'b0;
                        r_blk_last  <= 1'b0;
                        if (r_blk_last) begin
                            r_state <= ST_IDLE;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= ST_CAPTURE;
                            r_idx   <= '0;
                        end
                    end
                end
                ST_ABORT: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_blk_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keccak_absorb_pad.sv
// Scoreboard bench for keccak_absorb_pad: a SHA3-512 instance and a SHAKE128 instance share one FIFO model.
module tb_keccak_absorb_pad;
    import keccak_pkg::*;

    typedef struct {
        logic [1599:0] so;
        int            bc;
        bit            last;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passes = 0;

    logic          clk = 1'b0;
    logic          reset, go, kill, data_done, blk_ready, sel;
    logic [1599:0] state_in;
    logic [7:0]    fifo_dout;

    logic          rd1, v1, l1, busy1, done1;
    logic [6:0]    bc1;
    logic [1599:0] so1;
    logic          rd2, v2, l2, busy2, done2;
    logic [7:0]    bc2;
    logic [1599:0] so2;

    logic [7:0] mem [0:1023];
    logic [7:0] msg [0:255];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    int         cyc = 0;
    logic       bubble_en = 1'b0;
    logic       fifo_flush = 1'b0;

    always #5 clk = ~clk;

    wire           bubble       = bubble_en && (cyc % 3 == 0);
    wire           fifo_empty_m = (rd_ptr == wr_ptr) || bubble;
    wire           fifo_rd_m    = sel ? rd2 : rd1;
    wire           blk_valid_m  = sel ? v2 : v1;
    wire           last_m       = sel ? l2 : l1;
    wire           busy_m       = sel ? busy2 : busy1;
    wire           done_m       = sel ? done2 : done1;
    wire [7:0]     bc_m         = sel ? bc2 : {1'b0, bc1};
    wire [1599:0]  state_out_m  = sel ? so2 : so1;

    keccak_absorb_pad #(.RATE_BYTES(72), .DOMAIN(8'h06)) u_sha3 (
        .clk(clk), .reset(reset), .go(go & ~sel), .kill(kill), .data_done(data_done),
        .fifo_dout(fifo_dout), .fifo_empty(sel ? 1'b1 : fifo_empty_m), .fifo_rd(rd1),
        .state_in(state_in), .state_out(so1), .blk_valid(v1), .blk_ready(blk_ready),
        .blk_last(l1), .byte_count(bc1), .busy(busy1), .done(done1)
    );

    keccak_absorb_pad #(.RATE_BYTES(168), .DOMAIN(8'h1F)) u_shake (
        .clk(clk), .reset(reset), .go(go & sel), .kill(kill), .data_done(data_done),
        .fifo_dout(fifo_dout), .fifo_empty(sel ? fifo_empty_m : 1'b1), .fifo_rd(rd2),
        .state_in(state_in), .state_out(so2), .blk_valid(v2), .blk_ready(blk_ready),
        .blk_last(l2), .byte_count(bc2), .busy(busy2), .done(done2)
    );

    // FIFO model with one-cycle read latency.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fifo_flush) begin
            rd_ptr <= wr_ptr;
        end else if (fifo_rd_m) begin
            fifo_dout <= mem[rd_ptr];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    function automatic int first_diff(logic [1599:0] a, logic [1599:0] b);
        for (int i = 0; i < 200; i++) begin
            if (a[8*i +: 8] !== b[8*i +: 8]) return i;
        end
        return 0;
    endfunction

    // Writes msg[0..len-1] to the FIFO and optionally pushes the padded blocks it must produce.
    task automatic load_msg(int len, int rate, logic [7:0] dom, bit expect_blocks);
        int nblk;
        nblk = len / rate + 1;
        if (expect_blocks) begin
            for (int b = 0; b < nblk; b++) begin
                exp_t          e;
                logic [1599:0] blk;
                int            cnt;
                blk = '0;
                cnt = (b == nblk - 1) ? len - b * rate : rate;
                for (int i = 0; i < cnt; i++) blk[8*i +: 8] = msg[b*rate + i];
                if (b == nblk - 1) begin
                    blk[8*cnt +: 8]      = blk[8*cnt +: 8] ^ dom;
                    blk[8*(rate-1) +: 8] = blk[8*(rate-1) +: 8] ^ 8'h80;
                end
                e.so   = state_in ^ blk;
                e.bc   = cnt;
                e.last = (b == nblk - 1);
                sb.push_back(e);
            end
        end
        for (int i = 0; i < len; i++) begin
            mem[wr_ptr] = msg[i];
            wr_ptr++;
        end
    endtask

    task automatic start_msg(bit with_done);
        @(negedge clk);
        go        = 1'b1;
        data_done = with_done;
        @(negedge clk);
        go        = 1'b0;
    endtask

    task automatic flush_fifo();
        @(negedge clk);
        fifo_flush = 1'b1;
        @(negedge clk);
        fifo_flush = 1'b0;
    endtask

    // Waits for a block, compares it against the scoreboard, stalls, then handshakes.
    task automatic recv_block(string tag, int hold);
        int            waited;
        int            k;
        exp_t          e;
        logic [1599:0] snap;
        logic [7:0]    snap_bc;
        waited = 0;
        while (!blk_valid_m && waited < 3000) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (!blk_valid_m) begin
            $display("FAIL %s_timeout: blk_valid got 0 want 1", tag);
            return;
        end
        passes++;
        checks++;
        if (sb.size() == 0) begin
            $display("FAIL %s_unexpected: got a block, want none", tag);
            return;
        end
        passes++;
        e = sb.pop_front();
        checks++;
        if (state_out_m !== e.so) begin
            k = first_diff(state_out_m, e.so);
            $display("FAIL %s_state_out: byte %0d got %h want %h", tag, k,
                     state_out_m[8*k +: 8], e.so[8*k +: 8]);
        end else passes++;
        checks++;
        if (bc_m !== 8'(e.bc)) $display("FAIL %s_byte_count: got %0d want %0d", tag, bc_m, e.bc);
        else passes++;
        checks++;
        if (last_m !== e.last) $display("FAIL %s_blk_last: got %b want %b", tag, last_m, e.last);
        else passes++;
        snap    = state_out_m;
        snap_bc = bc_m;
        repeat (hold) begin
            @(negedge clk);
            checks++;
            if (fifo_rd_m !== 1'b0 || blk_valid_m !== 1'b1 || state_out_m !== snap || bc_m !== snap_bc)
                $display("FAIL %s_hold: fifo_rd=%b valid=%b count=%0d got, want 0/1/%0d and stable state",
                         tag, fifo_rd_m, blk_valid_m, bc_m, snap_bc);
            else passes++;
        end
        blk_ready = 1'b1;
        @(negedge clk);
        blk_ready = 1'b0;
        checks++;
        if (blk_valid_m !== 1'b0 || done_m !== e.last)
            $display("FAIL %s_accept: valid=%b done=%b got, want valid=0 done=%b", tag, blk_valid_m, done_m, e.last);
        else passes++;
        if (e.last) begin
            @(negedge clk);
            checks++;
            if (done_m !== 1'b0) $display("FAIL %s_done_pulse: done got %b want 0", tag, done_m);
            else passes++;
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 50; i++) state_in[32*i +: 32] = $urandom;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (fifo_rd_m !== 1'b0 || blk_valid_m !== 1'b0 || last_m !== 1'b0 || bc_m !== 8'd0 ||
            busy_m !== 1'b0 || done_m !== 1'b0)
            $display("FAIL reset_outputs: rd=%b v=%b l=%b bc=%0d busy=%b done=%b got, want all 0",
                     fifo_rd_m, blk_valid_m, last_m, bc_m, busy_m, done_m);
        else passes++;
        checks++;
        if (state_out_m !== state_in) $display("FAIL reset_state_out: byte %0d differs from state_in",
                                               first_diff(state_out_m, state_in));
        else passes++;
        reset = 1'b0;
        state_in = '0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
        load_msg(3, 72, 8'h06, 1'b1);
        start_msg(1'b1);
        checks++;
        if (busy_m !== 1'b1) $display("FAIL basic_busy: got %b want 1", busy_m);
        else passes++;
        recv_block("basic", 0);
        data_done = 1'b0;
    endtask

    task automatic test_empty();
        load_msg(0, 72, 8'h06, 1'b1);
        start_msg(1'b1);
        recv_block("empty", 0);
        data_done = 1'b0;
    endtask

    task automatic test_boundary();
        for (int i = 0; i < 72; i++) msg[i] = 8'(i + 1);
        load_msg(71, 72, 8'h06, 1'b1);
        start_msg(1'b1);
        recv_block("len71", 0);
        data_done = 1'b0;
        load_msg(72, 72, 8'h06, 1'b1);
        start_msg(1'b1);
        recv_block("len72_b1", 0);
        recv_block("len72_b2", 0);
        data_done = 1'b0;
    endtask

    task automatic test_bubbles_stall();
        int w;
        for (int i = 0; i < 50; i++) state_in[32*i +: 32] = $urandom;
        for (int i = 0; i < 100; i++) msg[i] = 8'($urandom);
        load_msg(100, 72, 8'h06, 1'b1);
        bubble_en = 1'b1;
        start_msg(1'b0);
        recv_block("stall_b1", 5);
        w = 0;
        while (rd_ptr != wr_ptr && w < 2000) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (rd_ptr != wr_ptr) $display("FAIL stall_drain: fifo level got %0d want 0", wr_ptr - rd_ptr);
        else passes++;
        bubble_en = 1'b0;
        data_done = 1'b1;
        recv_block("stall_b2", 5);
        data_done = 1'b0;
        state_in  = '0;
    endtask

    task automatic test_kill();
        int nrd;
        int w;
        for (int i = 0; i < 20; i++) msg[i] = 8'hA0 + 8'(i);
        load_msg(20, 72, 8'h06, 1'b0);
        start_msg(1'b0);
        nrd = 0;
        w   = 0;
        while (nrd < 10 && w < 200) begin
            if (fifo_rd_m) nrd++;
            @(negedge clk);
            w++;
        end
        checks++;
        if (nrd != 10) $display("FAIL kill_reads: got %0d reads want 10", nrd);
        else passes++;
        kill = 1'b1;
        #1;
        checks++;
        if (fifo_rd_m !== 1'b0) $display("FAIL kill_fifo_rd: got %b want 0", fifo_rd_m);
        else passes++;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (busy_m !== 1'b1 || blk_valid_m !== 1'b0 || done_m !== 1'b0 || fifo_rd_m !== 1'b0)
                $display("FAIL kill_abort: busy=%b v=%b done=%b rd=%b got, want 1/0/0/0",
                         busy_m, blk_valid_m, done_m, fifo_rd_m);
            else passes++;
        end
        kill = 1'b0;
        @(negedge clk);
        checks++;
        if (busy_m !== 1'b0 || blk_valid_m !== 1'b0 || done_m !== 1'b0)
            $display("FAIL kill_idle: busy=%b v=%b done=%b got, want 0/0/0", busy_m, blk_valid_m, done_m);
        else passes++;
        flush_fifo();
        test_basic();
    endtask

    task automatic test_shake_and_reset();
        sel = 1'b1;
        for (int i = 0; i < 168; i++) msg[i] = 8'($urandom);
        load_msg(168, 168, 8'h1F, 1'b1);
        start_msg(1'b1);
        recv_block("shake_b1", 0);
        recv_block("shake_b2", 2);
        data_done = 1'b0;
        for (int i = 0; i < 50; i++) state_in[32*i +: 32] = $urandom;
        for (int i = 0; i < 50; i++) msg[i] = 8'(i);
        load_msg(50, 168, 8'h1F, 1'b0);
        start_msg(1'b0);
        repeat (10) @(negedge clk);
        checks++;
        if (busy_m !== 1'b1) $display("FAIL midreset_busy: got %b want 1", busy_m);
        else passes++;
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (fifo_rd_m !== 1'b0 || blk_valid_m !== 1'b0 || last_m !== 1'b0 || bc_m !== 8'd0 ||
            busy_m !== 1'b0 || done_m !== 1'b0 || state_out_m !== state_in)
            $display("FAIL midreset_outputs: rd=%b v=%b l=%b bc=%0d busy=%b done=%b got, want all 0",
                     fifo_rd_m, blk_valid_m, last_m, bc_m, busy_m, done_m);
        else passes++;
        reset = 1'b0;
        flush_fifo();
        sel = 1'b0;
    endtask

    initial begin
        reset = 1'b1; go = 1'b0; kill = 1'b0; data_done = 1'b0; blk_ready = 1'b0; sel = 1'b0;
        state_in = '0;
        test_reset();
        test_basic();
        test_empty();
        test_boundary();
        test_bubbles_stall();
        test_kill();
        test_shake_and_reset();
        checks++;
        if (sb.size() != 0) $display("FAIL scoreboard_left: got %0d blocks want 0", sb.size());
        else passes++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
